// File: rtl/uart_rx_frame_check_if.sv
// Bit-strobe / frame-result bundle between the RX sampler side and the frame checker.
interface uart_rx_frame_check_if #(
    parameter int DWIDTH = 8
);
    logic              bit_valid;
    logic              sampled_bit;
    logic              busy;
    logic [DWIDTH-1:0] p_data;
    logic              data_valid;
    logic              parity_error;
    logic              frame_error;

    modport master (
        output bit_valid, sampled_bit,
        input  busy, p_data, data_valid, parity_error, frame_error
    );

    modport slave (
        input  bit_valid, sampled_bit,
        output busy, p_data, data_valid, parity_error, frame_error
    );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: start/data/parity/stop tracking, parity and framing checks.
// Error counters are built only when UART_RX_ERR_CNT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a 0 strobe (start bit)
// S_DATA   | shifting in DWIDTH data bits, LSB first
// S_PARITY | checking the parity bit against running parity
// S_STOP1  | first stop bit; completes unless two stops
// S_STOP2  | second stop bit; always completes
module uart_rx_frame_check #(
    parameter int DWIDTH    = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_frame_check_if.slave  rx,
    input  logic                  parity_en,
    input  logic                  parity_type,
    input  logic                  stop2,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  frm_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DWIDTH - 1);

    state_t            state;
    logic [DWIDTH-1:0] shreg;
    logic [3:0]        bit_cnt;
    logic              run_par;
    logic              pen_l;
    logic              ptype_l;
    logic              stop2_l;
    logic              par_fail;
    logic              frm_fail;

    logic              done;
    logic              par_err_nxt;
    logic              frm_err_nxt;

    // The final stop bit's own value must feed the frame flag on the completion cycle.
    always_comb begin
        done        = 1'b0;
        if (rx.bit_valid && (state == S_STOP2 || (state == S_STOP1 && !stop2_l)))
            done = 1'b1;
        frm_err_nxt = frm_fail | ~rx.sampled_bit;
        par_err_nxt = pen_l & par_fail;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            run_par         <= 1'b0;
            pen_l           <= 1'b0;
            ptype_l         <= 1'b0;
            stop2_l         <= 1'b0;
            par_fail        <= 1'b0;
            frm_fail        <= 1'b0;
            rx.busy         <= 1'b0;
            rx.p_data       <= '0;
            rx.data_valid   <= 1'b0;
            rx.parity_error <= 1'b0;
            rx.frame_error  <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            if (rx.bit_valid) begin
                case (state)
                    S_IDLE: begin
                        if (!rx.sampled_bit) begin
                            state    <= S_DATA;
                            rx.busy  <= 1'b1;
                            pen_l    <= parity_en;
                            ptype_l  <= parity_type;
                            stop2_l  <= stop2;
                            bit_cnt  <= '0;
                            run_par  <= 1'b0;
                            par_fail <= 1'b0;
                            frm_fail <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {rx.sampled_bit, shreg[DWIDTH-1:1]};
                        run_par <= run_par ^ rx.sampled_bit;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT)
                            state <= pen_l ? S_PARITY : S_STOP1;
                    end
                    S_PARITY: begin
                        if (rx.sampled_bit != (run_par ^ ptype_l))
                            par_fail <= 1'b1;
                        state <= S_STOP1;
                    end
                    S_STOP1: begin
                        if (!rx.sampled_bit)
                            frm_fail <= 1'b1;
                        if (stop2_l)
                            state <= S_STOP2;
                    end
                    S_STOP2: ;
                    default: begin
                        state   <= S_IDLE;
                        rx.busy <= 1'b0;
                    end
                endcase

                if (done) begin
                    state           <= S_IDLE;
                    rx.busy         <= 1'b0;
                    rx.data_valid   <= 1'b1;
                    rx.p_data       <= shreg;
                    rx.parity_error <= par_err_nxt;
                    rx.frame_error  <= frm_err_nxt;
                end
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] par_cnt;
    logic [CNT_WIDTH-1:0] frm_cnt;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_cnt <= '0;
            frm_cnt <= '0;
        end else if (cnt_clr) begin
            par_cnt <= '0;
            frm_cnt <= '0;
        end else if (done) begin
            if (par_err_nxt && par_cnt != '1)
                par_cnt <= par_cnt + CNT_WIDTH'(1);
            if (frm_err_nxt && frm_cnt != '1)
                frm_cnt <= frm_cnt + CNT_WIDTH'(1);
        end
    end

    assign par_err_cnt = par_cnt;
    assign frm_err_cnt = frm_cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign par_err_cnt    = '0;
    assign frm_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (DWIDTH=8, CNT_WIDTH=2); counter expectations follow UART_RX_ERR_CNT_EN.
module tb_uart_rx_frame_check;

`ifdef UART_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic       cnt_clr;
    logic [1:0] par_err_cnt;
    logic [1:0] frm_err_cnt;

    int checks   = 0;
    int failures = 0;
    int dv_cnt   = 0;
    int dv_before;

    uart_rx_frame_check_if #(.DWIDTH(8)) rx ();

    uart_rx_frame_check #(.DWIDTH(8), .CNT_WIDTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx.slave),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .cnt_clr     (cnt_clr),
        .par_err_cnt (par_err_cnt),
        .frm_err_cnt (frm_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts data_valid cycles; a pulse longer than one cycle shows up as an extra count.
    always @(negedge clk) if (rx.data_valid === 1'b1) dv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    // Sends start, 8 data bits LSB first, optional parity, one or two stop bits.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic s1, input logic s2, input logic two,
                              input int gap, input int tog, input logic clr_last,
                              input logic tail);
        logic [11:0] bits;
        int n;
        bits    = '0;
        bits[8:1] = d;
        n = 9;
        if (pen) begin bits[n] = pbit; n++; end
        bits[n] = s1; n++;
        if (two) begin bits[n] = s2; n++; end
        for (int i = 0; i < n; i++) begin
            rx.bit_valid   = 1'b1;
            rx.sampled_bit = bits[i];
            cnt_clr        = clr_last && (i == n - 1);
            @(negedge clk);
            rx.bit_valid = 1'b0;
            cnt_clr      = 1'b0;
            if (i == 0) chk("busy_after_start", 32'(rx.busy), 32'd1);
            if (i == tog) stop2 = ~stop2;
            repeat (gap) @(negedge clk);
        end
        if (tail) repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        rx.bit_valid = 1'b0;
        rx.sampled_bit = 1'b1;
        parity_en = 1'b0;
        parity_type = 1'b0;
        stop2 = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(rx.busy), 0);
        chk("rst_dv",    32'(rx.data_valid), 0);
        chk("rst_pdata", 32'(rx.p_data), 0);
        chk("rst_perr",  32'(rx.parity_error), 0);
        chk("rst_ferr",  32'(rx.frame_error), 0);
        chk("rst_pcnt",  32'(par_err_cnt), 0);
        chk("rst_fcnt",  32'(frm_err_cnt), 0);
        rst = 1'b1;
        @(negedge clk);

        // Idle '1' strobe must not start a frame
        rx.bit_valid = 1'b1; rx.sampled_bit = 1'b1;
        @(negedge clk);
        rx.bit_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(rx.busy), 0);
        chk("idle_dv",   32'(dv_cnt), 0);

        // 0xA5 even parity (bit 0), one stop
        parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b0;
        dv_before = dv_cnt;
        send_frame(8'hA5, 1, 0, 1, 1, 0, 1, -1, 0, 1);
        chk("a5_dv",    32'(dv_cnt), 32'(dv_before + 1));
        chk("a5_data",  32'(rx.p_data), 32'hA5);
        chk("a5_perr",  32'(rx.parity_error), 0);
        chk("a5_ferr",  32'(rx.frame_error), 0);
        chk("a5_busy",  32'(rx.busy), 0);

        // 0x03 odd parity, wrong parity bit 0
        parity_type = 1'b1;
        send_frame(8'h03, 1, 0, 1, 1, 0, 1, -1, 0, 1);
        chk("odd_bad_data", 32'(rx.p_data), 32'h03);
        chk("odd_bad_perr", 32'(rx.parity_error), 1);
        chk("odd_bad_pcnt", 32'(par_err_cnt), cexp(1));
        send_frame(8'h03, 1, 1, 1, 1, 0, 1, -1, 0, 1);
        chk("odd_ok_perr", 32'(rx.parity_error), 0);
        chk("odd_ok_pcnt", 32'(par_err_cnt), cexp(1));

        // Two stops, second one 0; stop2 toggled low mid-frame
        parity_en = 1'b0; stop2 = 1'b1;
        dv_before = dv_cnt;
        send_frame(8'h3C, 0, 0, 1, 0, 1, 1, 3, 0, 1);
        chk("stop2_dv",   32'(dv_cnt), 32'(dv_before + 1));
        chk("stop2_data", 32'(rx.p_data), 32'h3C);
        chk("stop2_ferr", 32'(rx.frame_error), 1);
        chk("stop2_perr", 32'(rx.parity_error), 0);
        chk("stop2_fcnt", 32'(frm_err_cnt), cexp(1));

        // One stop latched; stop2 raised mid-frame must not add a stop bit
        stop2 = 1'b0;
        dv_before = dv_cnt;
        send_frame(8'h81, 0, 0, 1, 1, 0, 1, 2, 0, 1);
        chk("stop1_dv",   32'(dv_cnt), 32'(dv_before + 1));
        chk("stop1_data", 32'(rx.p_data), 32'h81);
        chk("stop1_ferr", 32'(rx.frame_error), 0);
        chk("stop1_busy", 32'(rx.busy), 0);
        stop2 = 1'b0;

        // Back-to-back frames, consecutive strobes: 0x0F then 0x07, even parity
        parity_en = 1'b1; parity_type = 1'b0;
        dv_before = dv_cnt;
        send_frame(8'h0F, 1, 0, 1, 1, 0, 0, -1, 0, 0);
        send_frame(8'h07, 1, 1, 1, 1, 0, 0, -1, 0, 1);
        chk("b2b_dv",   32'(dv_cnt), 32'(dv_before + 2));
        chk("b2b_data", 32'(rx.p_data), 32'h07);
        chk("b2b_perr", 32'(rx.parity_error), 0);

        // Parity-error frames to saturate a 2-bit counter (total errors 2..5)
        parity_type = 1'b1;
        send_frame(8'h00, 1, 0, 1, 1, 0, 1, -1, 0, 1);
        chk("sat_pcnt2", 32'(par_err_cnt), cexp(2));
        for (int k = 0; k < 3; k++) send_frame(8'h00, 1, 0, 1, 1, 0, 1, -1, 0, 1);
        chk("sat_pcnt3", 32'(par_err_cnt), cexp(3));
        chk("sat_perr",  32'(rx.parity_error), 1);

        // cnt_clr on a completion cycle with both errors
        send_frame(8'h00, 1, 0, 0, 1, 0, 1, -1, 1, 1);
        chk("clr_perr", 32'(rx.parity_error), 1);
        chk("clr_ferr", 32'(rx.frame_error), 1);
        chk("clr_pcnt", 32'(par_err_cnt), 0);
        chk("clr_fcnt", 32'(frm_err_cnt), 0);

        // Reset during the data bits of 0x55
        parity_en = 1'b0;
        dv_before = dv_cnt;
        rx.bit_valid = 1'b1; rx.sampled_bit = 1'b0; @(negedge clk);
        rx.sampled_bit = 1'b1; @(negedge clk);
        rx.sampled_bit = 1'b0; @(negedge clk);
        rx.sampled_bit = 1'b1; @(negedge clk);
        rst = 1'b0;
        rx.bit_valid = 1'b0;
        #1;
        chk("mrst_busy",  32'(rx.busy), 0);
        chk("mrst_dv",    32'(rx.data_valid), 0);
        chk("mrst_pdata", 32'(rx.p_data), 0);
        chk("mrst_perr",  32'(rx.parity_error), 0);
        chk("mrst_ferr",  32'(rx.frame_error), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_no_dv", 32'(dv_cnt), 32'(dv_before));
        send_frame(8'h55, 0, 0, 1, 1, 0, 1, -1, 0, 1);
        chk("post_rst_data", 32'(rx.p_data), 32'h55);
        chk("post_rst_ferr", 32'(rx.frame_error), 0);
        chk("post_rst_dv",   32'(dv_cnt), 32'(dv_before + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Frame-level checker for the UART receiver. It consumes the bit strobes produced by the data-sampling stage and tracks the start, data, optional parity and one or two stop bits with its own state machine. It assembles the data word, checks even/odd parity and stop-bit framing, and reports each finished frame as a one-cycle strobe with error flags. It replaces the single-bit parity comparator: it sits between the sampler and the RX output register, alongside the main RX FSM.

## Interface
- `DWIDTH`, default 8: data bits per frame, LSB first; legal range 5..9.
- `CNT_WIDTH`, default 8: width of each saturating error counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `bit_valid` in 1: one-cycle strobe; `sampled_bit` is a decided line bit this cycle (start, data, parity or stop).
- `sampled_bit` in 1: sampled line value.
- `parity_en` in 1: 1 = a parity bit follows the data bits.
- `parity_type` in 1: 0 = even, 1 = odd.
- `stop2` in 1: 1 = two stop bits expected.
- `cnt_clr` in 1: synchronous clear of both error counters.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `p_data` out DWIDTH: last received word, held until the next frame completes.
- `data_valid` out 1: one-cycle strobe marking frame completion.
- `parity_error` out 1: parity mismatch in the last frame; updated only when `data_valid` pulses.
- `frame_error` out 1: any expected stop bit sampled 0 in the last frame; updated only when `data_valid` pulses.
- `par_err_cnt` out CNT_WIDTH: saturating count of parity errors.
- `frm_err_cnt` out CNT_WIDTH: saturating count of frame errors.

## Operation
- States are IDLE, DATA, PARITY, STOP1 and STOP2. The FSM advances only on cycles with `bit_valid`=1.
- **IDLE:**
  - `sampled_bit`=0 accepts the start bit and moves to DATA.
  - On acceptance, `parity_en`, `parity_type` and `stop2` are latched. They are held constant for the whole frame, and mid-frame input changes are ignored.
  - The bit counter and the running parity are cleared.
  - `sampled_bit`=1 stays in IDLE.
- **DATA:**
  - Each bit shifts into the MSB of the shift register, so after DWIDTH bits bit 0 is the first received bit.
  - Running parity ^= bit.
  - After the DWIDTH-th bit: go to PARITY if parity is enabled, else STOP1.
- **PARITY:**
  - Expected bit = running parity XOR latched `parity_type`.
  - Mismatch sets an internal parity-fail bit.
  - Go to STOP1.
- **STOP1:**
  - `sampled_bit`=0 sets the internal frame-fail bit.
  - Go to STOP2 if the latched `stop2`=1; otherwise complete the frame.
- **STOP2:** same check as STOP1, then complete the frame.
- **Frame completion:**
  - `data_valid`=1 for one cycle and `p_data` loads the shift register.
  - `parity_error` and `frame_error` load the internal fail bits.
  - With parity disabled, `parity_error` loads 0.
  - The FSM returns to IDLE.
- The frame is never aborted on an error; the remaining bits are still consumed.
- **Counters:**
  - On the completion cycle, each counter increments by 1 if its error flag is set.
  - Counters hold at all-ones; they do not wrap.
  - `cnt_clr`=1 forces both counters to 0 and takes priority over a same-cycle increment.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `data_valid`, `parity_error` and `frame_error` are 0.
  - `p_data` and both counters are 0.
- All outputs are registered.
- `busy` rises the cycle after the start bit is accepted and falls the cycle after the last stop bit.
- Latency: `data_valid`, `p_data`, the error flags and the counter updates all appear one clock after the `bit_valid` cycle of the last stop bit.
- Back-to-back frames:
  - A start bit may be strobed in the cycle immediately after the last stop bit, when the FSM is back in IDLE.
  - `data_valid` of the previous frame and acceptance of the new start bit may coincide.
- `bit_valid` has no minimum spacing; consecutive-cycle strobes are legal.
- Reset asserted mid-frame immediately returns the FSM to IDLE and clears all outputs. No `data_valid` is produced for the partial frame.

## Configuration
- Macro `UART_RX_ERR_CNT_EN`:
  - Defined: both counters and `cnt_clr` behave as specified.
  - Undefined: no counter flops are built, `par_err_cnt` and `frm_err_cnt` are tied to 0, and `cnt_clr` is ignored.
- All other behaviour is identical in both builds.

## Test plan
- Even parity, 1 stop, DWIDTH=8, byte 0xA5 (bits 1,0,1,0,0,1,0,1, parity bit 0, stop 1) -> `p_data`=0xA5, `data_valid` for one cycle, `parity_error`=0, `frame_error`=0.
- Odd parity, byte 0x03 with wrong parity bit 0 -> `parity_error`=1 and `par_err_cnt` increments 0 to 1. Next good frame -> `parity_error`=0 and the count stays 1.
- `stop2`=1, first stop 1, second stop 0 -> `frame_error`=1 and `frm_err_cnt`=1. Toggling `stop2` mid-frame has no effect.
- Idle with a `sampled_bit`=1 strobe -> stays IDLE and `busy`=0. Reset during the DATA bits of byte 0x55 -> no `data_valid`, and all outputs are 0 after reset.
- CNT_WIDTH=2, with 5 parity-error frames -> the counter saturates at 3. `cnt_clr` on a completion cycle with an error -> counter = 0.
- Build without `UART_RX_ERR_CNT_EN` -> both counters read 0 after error frames, and the flags still behave as above.
